// File: rtl/addertree_pkg.sv
// Shared types, derived widths and arithmetic helpers
// for the streaming adder tree.
package addertree_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int swidth(input int iw, input int n);
        return iw + clog2(n) + 1;
    endfunction

    function automatic int accw(input int iw, input int n, input int ab);
        return swidth(iw, n) + ab;
    endfunction

    function automatic int lat(input int n);
        return clog2(n) + 2;
    endfunction

    function automatic longint sext(input longint v, input int w,
                                    input logic sgn);
        longint m;
        longint x;
        m = (longint'(1) << w) - 1;
        x = v & m;
        if (sgn && x[w-1]) x = x | ~m;
        return x;
    endfunction

    function automatic longint clip(input longint v, input longint lo,
                                    input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint clamp(input longint v, input int ow,
                                     input mode_t m);
        longint lo;
        longint hi;
        if (m == MODE_SIGNED) begin
            lo = -(longint'(1) << (ow - 1));
            hi = (longint'(1) << (ow - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << ow) - 1;
        end
        return clip(v, lo, hi);
    endfunction

endpackage

// File: rtl/addertree_stage.sv
// One registered level of the reduction tree with its
// valid/last/mode sideband; an odd trailing lane is paired with zero.
module addertree_stage
    import addertree_pkg::*;
#(
    parameter int NIN = 2,
    parameter int W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic signed [W-1:0] d [NIN],
    input  logic                v_in,
    input  logic                l_in,
    input  logic                s_in,
    output logic signed [W-1:0] q [(NIN+1)/2],
    output logic                v_out,
    output logic                l_out,
    output logic                s_out
);

    localparam int NOUT = (NIN + 1) / 2;

    logic signed [W-1:0] b [NOUT];

    for (genvar j = 0; j < NOUT; j++) begin : g_pair
        if (2 * j + 1 < NIN) begin : g_full
            assign b[j] = d[2*j+1];
        end else begin : g_pad
            assign b[j] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NOUT; j++) q[j] <= '0;
            v_out <= 1'b0;
            l_out <= 1'b0;
            s_out <= 1'b0;
        end else if (clear) begin
            for (int j = 0; j < NOUT; j++) q[j] <= '0;
            v_out <= 1'b0;
            l_out <= 1'b0;
            s_out <= 1'b0;
        end else begin
            for (int j = 0; j < NOUT; j++) q[j] <= d[2*j] + b[j];
            v_out <= v_in;
            l_out <= l_in;
            s_out <= s_in;
        end
    end

endmodule

// File: rtl/addertree_stream.sv
// Streaming adder tree: extend, reduce, accumulate per group,
// then clamp to the output width.
module addertree_stream
    import addertree_pkg::*;
#(
    parameter int NINPUTS = 1024,
    parameter int IWIDTH  = 8,
    parameter int OWIDTH  = 16,
    parameter int ACCBITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_signed,
    input  logic [IWIDTH-1:0] in_data [NINPUTS],
    output logic              out_valid,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    localparam int NSTAGES = clog2(NINPUTS);
    localparam int NPAD    = 1 << NSTAGES;
    localparam int SW      = swidth(IWIDTH, NINPUTS);
    localparam int ACCW    = accw(IWIDTH, NINPUTS, ACCBITS);
    localparam longint ACC_MIN = -(longint'(1) << (ACCW - 1));
    localparam longint ACC_MAX = (longint'(1) << (ACCW - 1)) - 1;

    // Mode is fixed by the first vector so later ones extend the same way.
    logic  in_open;
    mode_t in_mode;
    mode_t ext_mode;
    assign ext_mode = in_open ? in_mode : mode_t'(in_signed);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_open <= 1'b0;
            in_mode <= MODE_UNSIGNED;
        end else if (clear) begin
            in_open <= 1'b0;
            in_mode <= MODE_UNSIGNED;
        end else if (in_valid) begin
            in_open <= ~in_last;
            in_mode <= ext_mode;
        end
    end

    logic signed [SW-1:0] r0 [NINPUTS];
    logic signed [SW-1:0] s0 [NPAD];
    logic                 v0, l0, m0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NINPUTS; i++) r0[i] <= '0;
            v0 <= 1'b0;
            l0 <= 1'b0;
            m0 <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NINPUTS; i++) r0[i] <= '0;
            v0 <= 1'b0;
            l0 <= 1'b0;
            m0 <= 1'b0;
        end else begin
            for (int i = 0; i < NINPUTS; i++)
                r0[i] <= SW'(sext(longint'(in_data[i]), IWIDTH, ext_mode));
            v0 <= in_valid;
            l0 <= in_last;
            m0 <= ext_mode;
        end
    end

    for (genvar i = 0; i < NPAD; i++) begin : g_lane
        if (i < NINPUTS) begin : g_real
            assign s0[i] = r0[i];
        end else begin : g_zero
            assign s0[i] = '0;
        end
    end

    logic signed [SW-1:0] tree_sum;
    logic                 tv, tl, tm;
    logic                 pipe_busy;

    if (NSTAGES == 0) begin : g_flat
        assign tree_sum  = s0[0];
        assign tv        = v0;
        assign tl        = l0;
        assign tm        = m0;
        assign pipe_busy = v0;
    end else begin : g_tree
        logic [NSTAGES-1:0] sv;
        for (genvar k = 0; k < NSTAGES; k++) begin : g_st
            localparam int NI = NPAD >> k;
            logic signed [SW-1:0] q [NI/2];
            logic                 v, l, m;
            assign sv[k] = v;
            if (k == 0) begin : g_first
                addertree_stage #(.NIN(NI), .W(SW)) u_stage (
                    .clk(clk), .rst(rst), .clear(clear),
                    .d(s0), .v_in(v0), .l_in(l0), .s_in(m0),
                    .q(q), .v_out(v), .l_out(l), .s_out(m)
                );
            end else begin : g_next
                addertree_stage #(.NIN(NI), .W(SW)) u_stage (
                    .clk(clk), .rst(rst), .clear(clear),
                    .d(g_st[k-1].q), .v_in(g_st[k-1].v),
                    .l_in(g_st[k-1].l), .s_in(g_st[k-1].m),
                    .q(q), .v_out(v), .l_out(l), .s_out(m)
                );
            end
        end
        assign tree_sum  = g_st[NSTAGES-1].q[0];
        assign tv        = g_st[NSTAGES-1].v;
        assign tl        = g_st[NSTAGES-1].l;
        assign tm        = g_st[NSTAGES-1].m;
        assign pipe_busy = v0 | (|sv);
    end

    logic signed [ACCW-1:0] acc;
    logic                   sticky;
    logic                   grp_open;
    mode_t                  grp_mode;
    logic                   fin_valid;
    logic                   fin_sticky;
    logic signed [ACCW-1:0] fin_sum;
    mode_t                  fin_mode;
    mode_t                  cur_mode;
    longint                 sum_full;
    longint                 sum_sat;
    logic                   acc_ovf;

    always_comb begin
        cur_mode = grp_open ? grp_mode : mode_t'(tm);
        sum_full = longint'(acc) + longint'(tree_sum);
        sum_sat  = clip(sum_full, ACC_MIN, ACC_MAX);
        acc_ovf  = (sum_sat != sum_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            sticky     <= 1'b0;
            grp_open   <= 1'b0;
            grp_mode   <= MODE_UNSIGNED;
            fin_valid  <= 1'b0;
            fin_sticky <= 1'b0;
            fin_sum    <= '0;
            fin_mode   <= MODE_UNSIGNED;
        end else if (clear) begin
            acc       <= '0;
            sticky    <= 1'b0;
            grp_open  <= 1'b0;
            grp_mode  <= MODE_UNSIGNED;
            fin_valid <= 1'b0;
        end else begin
            fin_valid <= tv & tl;
            if (tv && tl) begin
                acc        <= '0;
                sticky     <= 1'b0;
                grp_open   <= 1'b0;
                grp_mode   <= MODE_UNSIGNED;
                fin_sum    <= ACCW'(sum_sat);
                fin_sticky <= sticky | acc_ovf;
                fin_mode   <= cur_mode;
            end else if (tv) begin
                acc      <= ACCW'(sum_sat);
                sticky   <= sticky | acc_ovf;
                grp_open <= 1'b1;
                grp_mode <= cur_mode;
            end
        end
    end

    longint clamped;
    always_comb clamped = clamp(longint'(fin_sum), OWIDTH, fin_mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clear || !fin_valid) begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            out_data  <= OWIDTH'(clamped);
            out_sat   <= fin_sticky | (clamped != longint'(fin_sum));
        end
    end

    assign busy = pipe_busy | fin_valid | grp_open;

endmodule
